// File: rtl/sram_chip_if.sv
`timescale 1ns/1ps
// Address and control pins of the 16-bit asynchronous-SRAM bus.
// The bidirectional DQ bus is a separate inout port on the responder.
interface sram_chip_if #(
    parameter int ADDR_W = 18
) ();
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );
endinterface

// File: rtl/sram_chip_responder.sv
`timescale 1ns/1ps
// Clocked stand-in for a 256K x 16 asynchronous SRAM: byte-lane writes, pipelined read return, access counters.
// Define SRAM_PROTO_CHECK_EN to build the protocol checker (proto_err / err_count); otherwise both tie to zero.
module sram_chip_responder #(
    parameter int ADDR_W   = 18,
    parameter int DEPTH    = 262144,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    sram_chip_if.slave  bus,
    inout  wire  [15:0] SRAM_DQ,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        proto_err,
    output logic [7:0]  err_count
);
    localparam int DATA_W = 16;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One extra bit keeps DEPTH == 2**ADDR_W representable as a divisor.
    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
        return IDX_W'({1'b0, a} % (ADDR_W+1)'(DEPTH));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] rd_word;
    logic              cs, we, oe;
    logic              wr_en, wr_any;
    logic              rd_pins, rd_smp;
    logic              any_vld, flush;
    logic [DATA_W-1:0] q;
    logic              ub_drv, lb_drv;

    assign idx     = to_index(bus.SRAM_ADDR);
    assign din     = SRAM_DQ;
    assign rd_word = mem[idx];
    assign cs      = !bus.SRAM_CE_N;
    assign we      = !bus.SRAM_WE_N;
    assign oe      = !bus.SRAM_OE_N;
    assign wr_en   = cs && we;
    assign wr_any  = wr_en && (!bus.SRAM_UB_N || !bus.SRAM_LB_N);
    assign rd_pins = cs && !we && oe;
    assign rd_smp  = rd_pins;
    // Driving WE_N low into a busy read pipeline kills every in-flight return.
    assign flush   = we && any_vld;

    // Array survives reset; lanes written independently.
    always_ff @(posedge clk) begin
        if (wr_en && !bus.SRAM_UB_N) mem[idx][15:8] <= din[15:8];
        if (wr_en && !bus.SRAM_LB_N) mem[idx][7:0]  <= din[7:0];
    end

    generate
        if (READ_LAT > 0) begin : g_pipe
            logic [DATA_W-1:0] data_p [READ_LAT];
            logic [1:0]        lane_p [READ_LAT];
            logic [READ_LAT-1:0] vld_p;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_p <= '0;
                end else if (flush) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= rd_smp;
                    for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            // Stage 1 snapshots the word itself, so later writes cannot alter it.
            always_ff @(posedge clk) begin
                data_p[0] <= rd_word;
                lane_p[0] <= {!bus.SRAM_UB_N, !bus.SRAM_LB_N};
                for (int i = 1; i < READ_LAT; i++) begin
                    data_p[i] <= data_p[i-1];
                    lane_p[i] <= lane_p[i-1];
                end
            end

            assign any_vld = |vld_p;
            assign q       = data_p[READ_LAT-1];
            assign ub_drv  = rst && rd_pins && vld_p[READ_LAT-1] && lane_p[READ_LAT-1][1];
            assign lb_drv  = rst && rd_pins && vld_p[READ_LAT-1] && lane_p[READ_LAT-1][0];
        end else begin : g_comb
            assign any_vld = 1'b0;
            assign q       = rd_word;
            assign ub_drv  = rst && rd_pins && !bus.SRAM_UB_N;
            assign lb_drv  = rst && rd_pins && !bus.SRAM_LB_N;
        end
    endgenerate

    assign SRAM_DQ[15:8] = ub_drv ? q[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = lb_drv ? q[7:0]  : 8'hzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_any) wr_count <= sat_inc16(wr_count);
            if (rd_smp) rd_count <= sat_inc16(rd_count);
        end
    end

`ifdef SRAM_PROTO_CHECK_EN
    logic null_acc, addr_oob, evt;

    assign null_acc = cs && bus.SRAM_UB_N && bus.SRAM_LB_N && (we || oe);
    assign addr_oob = (wr_en || rd_pins) && ({1'b0, bus.SRAM_ADDR} >= (ADDR_W+1)'(DEPTH));
    assign evt      = null_acc || flush || addr_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
            err_count <= '0;
        end else if (evt) begin
            proto_err <= 1'b1;
            err_count <= sat_inc8(err_count);
        end
    end
`else
    assign proto_err = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sram_chip_responder.sv
`timescale 1ns/1ps
// Directed bench: four responders (READ_LAT 0..3, DEPTH 1024) share one pin bus, each with its own DQ net.
module tb_sram_chip_responder;
    logic clk;
    logic rst;
    logic tb_oe;
    logic [15:0] tb_dq;
    int n_cmp;
    int n_fail;

    wire [15:0] dq0, dq1, dq2, dq3;
    logic [3:0][15:0] wr_c;
    logic [3:0][15:0] rd_c;
    logic [3:0]       perr;
    logic [3:0][7:0]  ecnt;

`ifdef SRAM_PROTO_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    sram_chip_if #(.ADDR_W(18)) bus ();

    assign dq0 = tb_oe ? tb_dq : 16'hzzzz;
    assign dq1 = tb_oe ? tb_dq : 16'hzzzz;
    assign dq2 = tb_oe ? tb_dq : 16'hzzzz;
    assign dq3 = tb_oe ? tb_dq : 16'hzzzz;

    sram_chip_responder #(.ADDR_W(18), .DEPTH(1024), .READ_LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq0),
        .wr_count(wr_c[0]), .rd_count(rd_c[0]), .proto_err(perr[0]), .err_count(ecnt[0]));
    sram_chip_responder #(.ADDR_W(18), .DEPTH(1024), .READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq1),
        .wr_count(wr_c[1]), .rd_count(rd_c[1]), .proto_err(perr[1]), .err_count(ecnt[1]));
    sram_chip_responder #(.ADDR_W(18), .DEPTH(1024), .READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq2),
        .wr_count(wr_c[2]), .rd_count(rd_c[2]), .proto_err(perr[2]), .err_count(ecnt[2]));
    sram_chip_responder #(.ADDR_W(18), .DEPTH(1024), .READ_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq3),
        .wr_count(wr_c[3]), .rd_count(rd_c[3]), .proto_err(perr[3]), .err_count(ecnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A released byte reads Z on a 4-state simulator and 0 on a 2-state one.
    function automatic bit rel8(input logic [7:0] b);
        return (b === 8'hzz) || (b === 8'h00);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic drive_wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        bus.SRAM_ADDR = a;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        tb_dq = d;
        tb_oe = 1'b1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        drive_wr(a, d, ub, lb);
        step();
        set_idle();
    endtask

    task automatic drive_rd(input logic [17:0] a, input logic ub, input logic lb);
        bus.SRAM_ADDR = a;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        tb_oe = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        step();
        step();
        drive_rd(18'h0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (!rel8(dq1[15:8]) || !rel8(dq1[7:0])) begin
            n_fail++;
            $display("FAIL reset_dq_l1: got %h want Z", dq1);
        end
        n_cmp++;
        if (!rel8(dq0[15:8]) || !rel8(dq0[7:0])) begin
            n_fail++;
            $display("FAIL reset_dq_l0: got %h want Z", dq0);
        end
        n_cmp++;
        if (wr_c[1] !== 16'd0 || rd_c[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got wr=%h rd=%h want 0/0", wr_c[1], rd_c[1]);
        end
        n_cmp++;
        if (perr[1] !== 1'b0 || ecnt[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err: got %b/%h want 0/00", perr[1], ecnt[1]);
        end
        set_idle();
        rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        do_reset();
        wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
        drive_rd(18'h00010, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dq0 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL t1_l0_comb: got %h want BEEF", dq0);
        end
        step();
        n_cmp++;
        if (dq1 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL t1_l1_return: got %h want BEEF", dq1);
        end
        set_idle();
        step();
        n_cmp++;
        if (wr_c[1] !== 16'd1 || rd_c[1] !== 16'd1) begin
            n_fail++;
            $display("FAIL t1_counts: got wr=%0d rd=%0d want 1/1", wr_c[1], rd_c[1]);
        end
    endtask

    task automatic test_byte_lanes();
        do_reset();
        wr(18'h00020, 16'hFFFF, 1'b0, 1'b0);
        wr(18'h00020, 16'h1234, 1'b1, 1'b0);
        drive_rd(18'h00020, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (dq1 !== 16'hFF34) begin
            n_fail++;
            $display("FAIL t2_merge: got %h want FF34", dq1);
        end
        drive_rd(18'h00020, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (!rel8(dq0[15:8]) || dq0[7:0] !== 8'h34) begin
            n_fail++;
            $display("FAIL t2_l0_lane: got %h want ZZ34", dq0);
        end
        step();
        n_cmp++;
        if (!rel8(dq1[15:8]) || dq1[7:0] !== 8'h34) begin
            n_fail++;
            $display("FAIL t2_l1_lane: got %h want ZZ34", dq1);
        end
        set_idle();
        step();
        n_cmp++;
        if (wr_c[1] !== 16'd2 || rd_c[1] !== 16'd2) begin
            n_fail++;
            $display("FAIL t2_counts: got wr=%0d rd=%0d want 2/2", wr_c[1], rd_c[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) wr(18'(i), 16'(i) * 16'h1111, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            a = (c < 4) ? 18'(c) : 18'd0;
            drive_rd(a, 1'b0, 1'b0);
            step();
            if (c < 4) begin
                n_cmp++;
                if (dq1 !== 16'(c) * 16'h1111) begin
                    n_fail++;
                    $display("FAIL t3_l1_c%0d: got %h want %h", c, dq1, 16'(c) * 16'h1111);
                end
            end
            if (c >= 1 && c < 5) begin
                n_cmp++;
                if (dq2 !== 16'(c - 1) * 16'h1111) begin
                    n_fail++;
                    $display("FAIL t3_l2_c%0d: got %h want %h", c, dq2, 16'(c - 1) * 16'h1111);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (dq3 !== 16'(c - 2) * 16'h1111) begin
                    n_fail++;
                    $display("FAIL t3_l3_c%0d: got %h want %h", c, dq3, 16'(c - 2) * 16'h1111);
                end
            end
        end
        set_idle();
        step();
        n_cmp++;
        if (rd_c[3] !== 16'd6) begin
            n_fail++;
            $display("FAIL t3_rd_count: got %0d want 6", rd_c[3]);
        end
    endtask

    task automatic test_turnaround();
        do_reset();
        wr(18'h00005, 16'hAAAA, 1'b0, 1'b0);
        drive_rd(18'h00005, 1'b0, 1'b0);
        step();
        drive_wr(18'h00005, 16'h5555, 1'b0, 1'b0);
        bus.SRAM_OE_N = 1'b0;
        #1;
        n_cmp++;
        if (dq1 !== 16'h5555) begin
            n_fail++;
            $display("FAIL t4_we_blocks_drive: got %h want 5555", dq1);
        end
        step();
        drive_rd(18'h00005, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (!rel8(dq2[15:8]) || !rel8(dq2[7:0])) begin
            n_fail++;
            $display("FAIL t4_l2_flushed: got %h want Z", dq2);
        end
        n_cmp++;
        if (dq0 !== 16'h5555) begin
            n_fail++;
            $display("FAIL t4_l0_new: got %h want 5555", dq0);
        end
        step();
        n_cmp++;
        if (dq1 !== 16'h5555) begin
            n_fail++;
            $display("FAIL t4_l1_readback: got %h want 5555", dq1);
        end
        set_idle();
        step();
        n_cmp++;
        if (perr[2] !== CHK || ecnt[2] !== 8'(CHK)) begin
            n_fail++;
            $display("FAIL t4_proto: got %b/%0d want %b/%0d", perr[2], ecnt[2], CHK, CHK);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        wr(18'h00030, 16'hC3C3, 1'b0, 1'b0);
        drive_rd(18'h00030, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (dq1 !== 16'hC3C3) begin
            n_fail++;
            $display("FAIL t5_pending: got %h want C3C3", dq1);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (!rel8(dq1[15:8]) || !rel8(dq1[7:0])) begin
            n_fail++;
            $display("FAIL t5_async_release: got %h want Z", dq1);
        end
        n_cmp++;
        if (wr_c[1] !== 16'd0 || rd_c[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL t5_counts_cleared: got wr=%0d rd=%0d want 0/0", wr_c[1], rd_c[1]);
        end
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (!rel8(dq3[15:8]) || !rel8(dq3[7:0]) || !rel8(dq2[15:8]) || !rel8(dq2[7:0])) begin
            n_fail++;
            $display("FAIL t5_no_late_drive: got l2=%h l3=%h want Z", dq2, dq3);
        end
        step();
        n_cmp++;
        if (dq1 !== 16'hC3C3) begin
            n_fail++;
            $display("FAIL t5_mem_survives: got %h want C3C3", dq1);
        end
        set_idle();
        step();
        n_cmp++;
        if (rd_c[1] !== 16'd1 || wr_c[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL t5_post_counts: got wr=%0d rd=%0d want 0/1", wr_c[1], rd_c[1]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_wr(18'h00100, 16'h0000, 1'b0, 1'b0);
        repeat (70000) step();
        set_idle();
        step();
        n_cmp++;
        if (wr_c[1] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL t6_wr_sat: got %h want FFFF", wr_c[1]);
        end
        wr(18'h00400, 16'h4242, 1'b0, 1'b0);
        drive_rd(18'h00000, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (dq1 !== 16'h4242) begin
            n_fail++;
            $display("FAIL t6_addr_wrap: got %h want 4242", dq1);
        end
        set_idle();
        step();
        n_cmp++;
        if (ecnt[1] !== 8'(CHK) || perr[1] !== CHK) begin
            n_fail++;
            $display("FAIL t6_oob_err: got %b/%0d want %b/%0d", perr[1], ecnt[1], CHK, CHK);
        end
        drive_wr(18'h00010, 16'h0000, 1'b1, 1'b1);
        step();
        set_idle();
        step();
        n_cmp++;
        if (ecnt[1] !== 8'(2 * CHK)) begin
            n_fail++;
            $display("FAIL t6_null_err: got %0d want %0d", ecnt[1], 2 * CHK);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        tb_dq = 16'h0000;
        bus.SRAM_ADDR = 18'h0;
        set_idle();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_turnaround();
        test_reset_mid_read();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
